// File: rtl/decadico_decrescente.sv
// BCD decade down-counter, DIGITS digits wide, with parallel load, count enable and borrow-out.
// clear is an active-low asynchronous reset that forces every digit to 9.
module decadico_decrescente #(
    parameter int DIGITS = 1,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   s,
    output logic                  zero,
    output logic                  borrow
);

    logic [4*DIGITS-1:0] s_q;
    logic [4*DIGITS-1:0] s_d;
    logic [4*DIGITS-1:0] d_clamp;
    logic [4*DIGITS-1:0] s_dec;
    logic [4*DIGITS-1:0] nines;

    always_comb begin
        d_clamp = '0;
        nines   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d_clamp[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd9 : d[4*i +: 4];
            nines[4*i +: 4]   = 4'd9;
        end
    end

    // Ripple borrow: a digit steps only when every lower digit is already zero.
    always_comb begin
        logic       brw;
        logic [3:0] nib;
        s_dec = s_q;
        brw   = 1'b1;
        nib   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = s_q[4*i +: 4];
            if (brw) begin
                s_dec[4*i +: 4] = (nib == 4'd0) ? 4'd9 : 4'(nib - 4'd1);
            end
            brw = brw & (nib == 4'd0);
        end
    end

    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = d_clamp;
        end else if (en) begin
            if (zero && !WRAP) begin
                s_d = s_q;
            end else begin
                s_d = s_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            s_q <= nines;
        end else begin
            s_q <= s_d;
        end
    end

    assign s      = s_q;
    assign zero   = (s_q == '0);
    assign borrow = en & ~load & zero;

endmodule
